// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_pkg                                                         |
// | Purpose  : Shared types and helpers for the execute-stage ALU: the 16      |
// |            ARM data-processing opcodes, NZCV bit positions and the         |
// |            opcode classification functions used by decode.                 |
// | Ports    : none (package)                                                  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
package alu_pkg;

   typedef enum logic [3:0] {
      CMD_AND = 4'h0,
      CMD_EOR = 4'h1,
      CMD_SUB = 4'h2,
      CMD_RSB = 4'h3,
      CMD_ADD = 4'h4,
      CMD_ADC = 4'h5,
      CMD_SBC = 4'h6,
      CMD_RSC = 4'h7,
      CMD_TST = 4'h8,
      CMD_TEQ = 4'h9,
      CMD_CMP = 4'hA,
      CMD_CMN = 4'hB,
      CMD_ORR = 4'hC,
      CMD_MOV = 4'hD,
      CMD_BIC = 4'hE,
      CMD_MVN = 4'hF
   } alu_cmd_e;

   // Bit positions inside the {N,Z,C,V} flag vector
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   // Opcodes that go through the adder and therefore produce C and V
   function automatic logic is_arith(input alu_cmd_e cmd);
      logic r;
      case (cmd)
         CMD_SUB, CMD_RSB, CMD_ADD, CMD_ADC,
         CMD_SBC, CMD_RSC, CMD_CMP, CMD_CMN: r = 1'b1;
         default:                            r = 1'b0;
      endcase
      return r;
   endfunction

   // TST/TEQ/CMP/CMN: always update flags, never write the register file
   function automatic logic is_cmp(input alu_cmd_e cmd);
      return (cmd == CMD_TST) || (cmd == CMD_TEQ) ||
             (cmd == CMD_CMP) || (cmd == CMD_CMN);
   endfunction

endpackage
`default_nettype wire

// File: rtl/mul_iter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : mul_iter                                                        |
// | Purpose  : Iterative shift-add multiplier, one multiplier bit per clock,   |
// |            WIDTH iterations; returns the low WIDTH bits of the product.    |
// | Ports    : clk, rst_n     clock / async active-low reset                   |
// |            start         load operands, clear accumulator                 |
// |            op_a, op_b    multiplicand / multiplier                        |
// |            done          high during the final iteration cycle            |
// |            product       low WIDTH product bits, valid while done         |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module mul_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   output logic             done,
   output logic [WIDTH-1:0] product
);

   localparam int CNT_W = $clog2(WIDTH);

   logic [WIDTH-1:0] mcand;
   logic [WIDTH-1:0] mplier;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] acc_next;
   logic [CNT_W-1:0] cnt;
   logic             running;

   // Only the low WIDTH product bits are kept, so shifted-out multiplicand
   // bits can simply be dropped.
   assign acc_next = mplier[0] ? (acc + mcand) : acc;

   // The product is presented combinationally on the last iteration so the
   // caller can register it on the same edge the iteration completes.
   assign done    = running && (cnt == CNT_W'(WIDTH - 1));
   assign product = acc_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mcand   <= '0;
         mplier  <= '0;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b0;
      end else if (start) begin
         mcand   <= op_a;
         mplier  <= op_b;
         acc     <= '0;
         cnt     <= '0;
         running <= 1'b1;
      end else if (running) begin
         acc     <= acc_next;
         mcand   <= mcand << 1;
         mplier  <= mplier >> 1;
         cnt     <= cnt + 1'b1;
         if (done) begin
            running <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : alu_seq_unit                                                    |
// | Purpose  : Handshaked execute-stage ALU. Decodes the 16 ARM data-          |
// |            processing opcodes, owns the NZCV register and adds an         |
// |            iterative MUL (WIDTH+1 cycles). Other ops take one cycle.      |
// | Ports    : clk, rst_n            clock / async active-low reset           |
// |            in_valid, in_ready    input handshake                          |
// |            alu_op, s, cmd,       op select: plain ADD / S bit / opcode /  |
// |            is_mul                multiply override                        |
// |            src_a, src_b          operands (Rn, Op2)                       |
// |            out_valid, out_ready  output handshake                         |
// |            result, no_write      registered result / suppress RF write    |
// |            flags                 architectural {N,Z,C,V}                  |
// |            busy                  multiply iteration in progress           |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module alu_seq_unit
   import alu_pkg::*;
#(
   parameter int WIDTH      = 32,
   parameter bit MUL_ENABLE = 1'b1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic             alu_op,
   input  logic             s,
   input  logic [3:0]       cmd,
   input  logic             is_mul,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] result,
   output logic             no_write,
   output logic [3:0]       flags,
   output logic             busy
);

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_MUL  = 1'b1
   } state_e;

   state_e           state;
   state_e           state_next;
   logic             ready_en;     // holds in_ready low until the first edge after reset
   logic             accept;
   logic             start_mul;
   logic             load_single;
   logic             mul_s;        // S bit of the multiply in flight
   logic             mul_done;
   logic [WIDTH-1:0] mul_product;

   alu_cmd_e         op;
   logic [WIDTH-1:0] op1;
   logic [WIDTH-1:0] op2;
   logic             cin;
   logic [WIDTH:0]   sum;
   logic [WIDTH-1:0] logic_res;
   logic [WIDTH-1:0] op_result;
   logic             op_nw;
   logic [3:0]       op_flags;

   assign op   = alu_cmd_e'(cmd);
   assign busy = (state == ST_MUL);

   // ------------------------------------------------------------------
   // Operand steering. Every arithmetic opcode is folded onto one
   // WIDTH+1-bit add so C is the ARM carry / not-borrow directly.
   // ------------------------------------------------------------------
   always_comb begin
      op1       = src_a;
      op2       = src_b;
      cin       = 1'b0;
      logic_res = '0;
      case (op)
         CMD_SUB, CMD_CMP: begin op1 = src_a; op2 = ~src_b; cin = 1'b1;          end
         CMD_RSB:          begin op1 = src_b; op2 = ~src_a; cin = 1'b1;          end
         CMD_ADC:          begin op1 = src_a; op2 = src_b;  cin = flags[FLAG_C]; end
         CMD_SBC:          begin op1 = src_a; op2 = ~src_b; cin = flags[FLAG_C]; end
         CMD_RSC:          begin op1 = src_b; op2 = ~src_a; cin = flags[FLAG_C]; end
         default:          begin op1 = src_a; op2 = src_b;  cin = 1'b0;          end
      endcase
      case (op)
         CMD_AND, CMD_TST: logic_res = src_a & src_b;
         CMD_EOR, CMD_TEQ: logic_res = src_a ^ src_b;
         CMD_ORR:          logic_res = src_a | src_b;
         CMD_MOV:          logic_res = src_b;
         CMD_BIC:          logic_res = src_a & ~src_b;
         CMD_MVN:          logic_res = ~src_b;
         default:          logic_res = '0;
      endcase
   end

   assign sum = {1'b0, op1} + {1'b0, op2} + {{WIDTH{1'b0}}, cin};

   // ------------------------------------------------------------------
   // Single-cycle result, write-enable and next flags. A multiply only
   // reaches this path when the multiplier is not built.
   // ------------------------------------------------------------------
   always_comb begin
      op_result = '0;
      op_nw     = 1'b0;
      op_flags  = flags;
      if (is_mul) begin
         op_result = '0;
         op_nw     = 1'b1;
      end else if (!alu_op) begin
         op_result = src_a + src_b;
      end else begin
         op_result = is_arith(op) ? sum[WIDTH-1:0] : logic_res;
         op_nw     = is_cmp(op);
         if (s || is_cmp(op)) begin
            op_flags[FLAG_N] = op_result[WIDTH-1];
            op_flags[FLAG_Z] = (op_result == '0);
            if (is_arith(op)) begin
               op_flags[FLAG_C] = sum[WIDTH];
               // Overflow: both addends agree in sign but the sum does not
               op_flags[FLAG_V] = (op1[WIDTH-1] == op2[WIDTH-1]) &&
                                  (sum[WIDTH-1] != op1[WIDTH-1]);
            end
         end
      end
   end

   // ------------------------------------------------------------------
   // Control FSM: next state and handshake decode
   // ------------------------------------------------------------------
   always_comb begin
      state_next  = state;
      in_ready    = ready_en && (state == ST_IDLE) && (!out_valid || out_ready);
      accept      = in_valid && in_ready;
      start_mul   = 1'b0;
      load_single = 1'b0;
      case (state)
         ST_IDLE: begin
            if (accept) begin
               if (is_mul && MUL_ENABLE) begin
                  start_mul  = 1'b1;
                  state_next = ST_MUL;
               end else begin
                  load_single = 1'b1;
               end
            end
         end
         ST_MUL: begin
            if (mul_done) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ------------------------------------------------------------------
   // Optional iterative multiplier
   // ------------------------------------------------------------------
   generate
      if (MUL_ENABLE) begin : g_mul
         mul_iter #(
            .WIDTH   (WIDTH)
         ) u_mul_iter (
            .clk     (clk),
            .rst_n   (rst_n),
            .start   (start_mul),
            .op_a    (src_a),
            .op_b    (src_b),
            .done    (mul_done),
            .product (mul_product)
         );
      end else begin : g_no_mul
         assign mul_done    = 1'b0;
         assign mul_product = '0;
      end
   endgenerate

   // ------------------------------------------------------------------
   // Output / flag registers. A new load wins over the handshake clear,
   // which lets a fresh op replace a consumed result on the same edge.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ready_en  <= 1'b0;
         out_valid <= 1'b0;
         result    <= '0;
         no_write  <= 1'b0;
         flags     <= 4'b0000;
         mul_s     <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         if (start_mul) begin
            mul_s <= s;
         end
         if (load_single) begin
            out_valid <= 1'b1;
            result    <= op_result;
            no_write  <= op_nw;
            flags     <= op_flags;
         end else if (mul_done) begin
            out_valid <= 1'b1;
            result    <= mul_product;
            no_write  <= 1'b0;
            if (mul_s) begin
               flags[FLAG_N] <= mul_product[WIDTH-1];
               flags[FLAG_Z] <= (mul_product == '0);
            end
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_seq_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_alu_seq_unit                                                 |
// | Purpose  : Self-checking bench for alu_seq_unit (WIDTH=32) with an        |
// |            arithmetic reference model and directed vectors.               |
// | Ports    : none                                                            |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_alu_seq_unit;
   import alu_pkg::*;

   localparam int     W    = 32;
   localparam longint SMAX = 64'sd2147483647;
   localparam longint SMIN = -64'sd2147483648;
   localparam longint TWO32 = 64'sd4294967296;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_ready;
   logic          alu_op = 1'b1;
   logic          s = 1'b0;
   logic [3:0]    cmd = 4'h0;
   logic          is_mul = 1'b0;
   logic [W-1:0]  src_a = '0;
   logic [W-1:0]  src_b = '0;
   logic          out_valid;
   logic          out_ready = 1'b1;
   logic [W-1:0]  result;
   logic          no_write;
   logic [3:0]    flags;
   logic          busy;

   always #5 clk = ~clk;

   alu_seq_unit #(
      .WIDTH      (W),
      .MUL_ENABLE (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .alu_op    (alu_op),
      .s         (s),
      .cmd       (cmd),
      .is_mul    (is_mul),
      .src_a     (src_a),
      .src_b     (src_b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .result    (result),
      .no_write  (no_write),
      .flags     (flags),
      .busy      (busy)
   );

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   typedef struct {
      logic [31:0] res;
      logic        nw;
      logic [3:0]  fl;
      int          acc_cyc;
      int          lat;
      bit          seen;
   } exp_t;

   exp_t       q[$];
   logic [3:0] mflags = 4'b0000;

   function automatic exp_t model(input logic aop, input logic s_i, input logic [3:0] c,
                                  input logic m, input logic [31:0] a, input logic [31:0] b,
                                  input logic [3:0] fin);
      exp_t            e;
      longint          ua, ub, sa, sb, u, sv, ci;
      longint unsigned p;
      bit              arith, cf;
      ua = longint'(a);  ub = longint'(b);
      sa = longint'($signed(a)); sb = longint'($signed(b));
      ci = longint'(fin[1]);
      u = 0; sv = 0; arith = 0; cf = 0; p = 0;
      e.fl = fin; e.nw = 1'b0; e.lat = 1; e.res = '0; e.acc_cyc = 0; e.seen = 0;
      if (m) begin
         p = longint'(ua) * longint'(ub);
         e.res = p[31:0];
         e.lat = W + 1;
         if (s_i) begin e.fl[3] = e.res[31]; e.fl[2] = (e.res == 0); end
      end else if (!aop) begin
         u = ua + ub;
         e.res = u[31:0];
      end else begin
         case (c)
            4'h0, 4'h8: e.res = a & b;
            4'h1, 4'h9: e.res = a ^ b;
            4'hC:       e.res = a | b;
            4'hD:       e.res = b;
            4'hE:       e.res = a & ~b;
            4'hF:       e.res = ~b;
            4'h4, 4'hB: begin u = ua + ub;            sv = sa + sb;            cf = (u >= TWO32); arith = 1; end
            4'h5:       begin u = ua + ub + ci;       sv = sa + sb + ci;       cf = (u >= TWO32); arith = 1; end
            4'h2, 4'hA: begin u = ua - ub;            sv = sa - sb;            cf = (u >= 0);     arith = 1; end
            4'h3:       begin u = ub - ua;            sv = sb - sa;            cf = (u >= 0);     arith = 1; end
            4'h6:       begin u = ua - ub - (1 - ci); sv = sa - sb - (1 - ci); cf = (u >= 0);     arith = 1; end
            default:    begin u = ub - ua - (1 - ci); sv = sb - sa - (1 - ci); cf = (u >= 0);     arith = 1; end
         endcase
         if (arith) e.res = u[31:0];
         e.nw = (c >= 4'h8) && (c <= 4'hB);
         if (s_i || e.nw) begin
            e.fl[3] = e.res[31];
            e.fl[2] = (e.res == 0);
            if (arith) begin
               e.fl[1] = cf;
               e.fl[0] = (sv > SMAX) || (sv < SMIN);
            end
         end
      end
      return e;
   endfunction

   // ---------------- driver ----------------
   task automatic issue(input logic aop, input logic s_i, input logic [3:0] c,
                        input logic m, input logic [31:0] a, input logic [31:0] b);
      int   n;
      exp_t e;
      n = 0;
      in_valid = 1'b1; alu_op = aop; s = s_i; cmd = c; is_mul = m; src_a = a; src_b = b;
      while (!in_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!in_ready) begin
         tests++; fails++;
         $display("FAIL issue_timeout: in_ready got 0 expected 1 after %0d cycles", n);
         in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      e = model(aop, s_i, c, m, a, b, mflags);
      e.acc_cyc = cyc;
      q.push_back(e);
      mflags = e.fl;
      #1 in_valid = 1'b0;
   endtask

   // ---------------- compare process ----------------
   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (q.size() == 0) begin
            tests++; fails++;
            $display("FAIL spurious_out_valid: got result %h expected no output", result);
         end else begin
            if (!q[0].seen) begin
               chk("latency", cyc - q[0].acc_cyc, q[0].lat);
               q[0].seen = 1;
            end
            chk("result",   result,   q[0].res);
            chk("no_write", no_write, q[0].nw);
            chk("flags",    flags,    q[0].fl);
            if (out_ready) void'(q.pop_front());
         end
      end
   end

   typedef struct {
      logic [3:0]  c;
      logic        s_i;
      logic [31:0] a;
      logic [31:0] b;
   } vec_t;

   vec_t vt[14] = '{
      '{4'h1, 1'b1, 32'hF0F0F0F0, 32'hFF00FF00},  // EOR
      '{4'h3, 1'b1, 32'h00000005, 32'h00000003},  // RSB 3-5
      '{4'h6, 1'b1, 32'h80000000, 32'h00000001},  // SBC
      '{4'h7, 1'b1, 32'h00000001, 32'h00000000},  // RSC
      '{4'h8, 1'b0, 32'h0000000F, 32'h000000F0},  // TST -> Z
      '{4'h9, 1'b0, 32'h00000005, 32'h00000005},  // TEQ
      '{4'hB, 1'b0, 32'hFFFFFFFF, 32'h00000001},  // CMN -> Z,C
      '{4'hC, 1'b1, 32'h80000000, 32'h00000001},  // ORR keeps C,V
      '{4'hD, 1'b1, 32'h00000000, 32'h00000000},  // MOV 0
      '{4'hE, 1'b1, 32'h000000FF, 32'h0000000F},  // BIC
      '{4'hF, 1'b1, 32'h00000000, 32'h00000000},  // MVN
      '{4'h0, 1'b0, 32'h12345678, 32'h0F0F0F0F},  // AND no S
      '{4'h2, 1'b1, 32'h80000000, 32'h00000001},  // SUB overflow
      '{4'h5, 1'b1, 32'hFFFFFFFF, 32'h00000000}   // ADC carry chain
   };

   initial begin
      // watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      #2;
      chk("reset_in_ready",  in_ready,  0);
      chk("reset_out_valid", out_valid, 0);
      chk("reset_result",    result,    0);
      chk("reset_no_write",  no_write,  0);
      chk("reset_flags",     flags,     0);
      chk("reset_busy",      busy,      0);
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("ready_after_reset", in_ready, 1);

      // ADD with signed overflow
      issue(1, 1, CMD_ADD, 0, 32'h7FFFFFFF, 32'h1);
      @(negedge clk);
      chk("add_ovf_valid",  out_valid, 1);
      chk("add_ovf_result", result, 32'h80000000);
      chk("add_ovf_flags",  flags, 4'b1001);

      // CMP then dependent ADC back to back
      issue(1, 0, CMD_CMP, 0, 32'd5, 32'd5);
      chk("cmp_flags",    flags, 4'b0110);
      chk("cmp_no_write", no_write, 1);
      issue(1, 0, CMD_ADC, 0, 32'd0, 32'd0);
      @(negedge clk);
      chk("adc_result", result, 32'd1);
      chk("adc_flags",  flags, 4'b0110);

      // MUL 3*7
      issue(1, 1, 4'h0, 1, 32'd3, 32'd7);
      for (int i = 0; i < W; i++) begin
         @(negedge clk);
         chk("mul_busy_noready", {busy, in_ready, out_valid}, 3'b100);
      end
      @(negedge clk);
      chk("mul_valid",  {out_valid, busy}, 2'b10);
      chk("mul_result", result, 32'd21);
      chk("mul_flags",  flags, 4'b0010);

      // Output back-pressure
      @(posedge clk); #1 out_ready = 1'b0;
      issue(1, 0, CMD_ADD, 0, 32'd10, 32'd20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("hold_state", {out_valid, in_ready}, 2'b10);
         chk("hold_result", result, 32'd30);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      in_valid = 1'b1; alu_op = 1'b1; s = 1'b1; cmd = CMD_SUB; is_mul = 1'b0;
      src_a = 32'd3; src_b = 32'd5;
      #1 chk("release_ready", in_ready, 1);
      issue(1, 1, CMD_SUB, 0, 32'd3, 32'd5);
      @(negedge clk);
      chk("sub_neg_result", result, 32'hFFFFFFFE);
      chk("sub_neg_flags",  flags, 4'b1000);

      // alu_op=0 plain add leaves flags alone
      issue(0, 1, CMD_ADD, 0, 32'hFFFFFFFF, 32'h1);
      @(negedge clk);
      chk("addr_result",   result, 32'h0);
      chk("addr_flags",    flags, 4'b1000);
      chk("addr_no_write", no_write, 0);

      // Mixed opcode table, checked by the model
      foreach (vt[i]) issue(1, vt[i].s_i, vt[i].c, 0, vt[i].a, vt[i].b);

      // Reset in the middle of a multiply
      issue(1, 1, 4'h0, 1, 32'd5, 32'd6);
      repeat (10) @(negedge clk);
      rst_n = 1'b0;
      q.delete();
      mflags = 4'b0000;
      #1;
      chk("abort_outputs", {out_valid, busy, in_ready, no_write}, 4'b0000);
      chk("abort_result",  result, 32'h0);
      chk("abort_flags",   flags, 4'b0000);
      @(negedge clk) rst_n = 1'b1;
      @(posedge clk); #1;
      issue(1, 0, CMD_ADD, 0, 32'd2, 32'd2);
      @(negedge clk);
      chk("post_reset_add", result, 32'd4);
      chk("post_reset_flags", flags, 4'b0000);

      repeat (3) @(negedge clk);
      chk("queue_drained", q.size(), 0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
`default_nettype wire
